// File: rtl/ram_dma_engine.sv
// ram_dma_engine: block FILL / CHECKSUM / COPY sequencer for a single-port synchronous RAM.
// Optional build macro RAM_DMA_FILL_INC_EN: op 11 becomes FILL_INC (incrementing fill) and COPY is removed.

module ram_dma_engine #(
  parameter int A = 10,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [A-1:0] cmd_src,
  input  logic [A-1:0] cmd_dst,
  input  logic [A:0]   cmd_len,
  input  logic [D-1:0] cmd_data,
  output logic         busy,
  output logic         done,
  output logic [D-1:0] result,
  output logic [A-1:0] mem_addr,
  output logic [D-1:0] mem_din,
  output logic         mem_we,
  input  logic [D-1:0] mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RD,
    S_WR,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [1:0]   OP_NOP   = 2'b00;
  localparam logic [1:0]   OP_FILL  = 2'b01;
  localparam logic [1:0]   OP_SUM   = 2'b10;
  localparam logic [A-1:0] ADDR_ONE = 1;
  localparam logic [A:0]   CNT_ONE  = 1;
  localparam logic [D-1:0] DATA_ONE = 1;

  state_e       state_q, state_d;
  logic [A:0]   cnt_q, cnt_d;          // words still to issue after the current one
  logic [A-1:0] src_q, src_d;
  logic [A-1:0] dst_q, dst_d;
  logic [D-1:0] pat_q, pat_d;
  logic         inc_q, inc_d;
  logic         copy_q, copy_d;
  logic         pend_q, pend_d;        // a checksum read was issued last cycle
  logic [D-1:0] acc_q, acc_d;
  logic [D-1:0] result_q, result_d;
  logic [A-1:0] mem_addr_q, mem_addr_d;
  logic [D-1:0] mem_din_q, mem_din_d;
  logic         mem_we_q, mem_we_d;

  always_comb begin
    // NOTE: every _d starts from its _q, so no branch can leave a signal unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    src_d      = src_q;
    dst_d      = dst_q;
    pat_d      = pat_q;
    inc_d      = inc_q;
    copy_d     = copy_q;
    pend_d     = pend_q;
    acc_d      = acc_q;
    result_d   = result_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = mem_we_q;

    unique case (state_q)
      S_IDLE: begin
        mem_we_d = 1'b0;
        if (cmd_valid) begin
          cnt_d    = cmd_len - CNT_ONE;
          src_d    = cmd_src;
          dst_d    = cmd_dst;
          pat_d    = cmd_data;
          inc_d    = 1'b0;
          copy_d   = 1'b0;
          pend_d   = 1'b0;
          acc_d    = '0;
          result_d = '0;
          if (cmd_op == OP_NOP || cmd_len == '0) begin
            state_d = S_DONE;
          end else if (cmd_op == OP_FILL) begin
            state_d    = S_FILL;
            mem_we_d   = 1'b1;
            mem_addr_d = cmd_dst;
            mem_din_d  = cmd_data;
            dst_d      = cmd_dst + ADDR_ONE;
          end else if (cmd_op == OP_SUM) begin
            state_d    = S_RD;
            mem_addr_d = cmd_src;
            src_d      = cmd_src + ADDR_ONE;
          end else begin
`ifdef RAM_DMA_FILL_INC_EN
            state_d    = S_FILL;
            inc_d      = 1'b1;
            mem_we_d   = 1'b1;
            mem_addr_d = cmd_dst;
            mem_din_d  = cmd_data;
            dst_d      = cmd_dst + ADDR_ONE;
            pat_d      = cmd_data + DATA_ONE;
`else
            state_d    = S_RD;
            copy_d     = 1'b1;
            mem_addr_d = cmd_src;
            src_d      = cmd_src + ADDR_ONE;
`endif
          end
        end
      end

      S_FILL: begin
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          mem_we_d = 1'b0;
        end else begin
          mem_addr_d = dst_q;
          mem_din_d  = pat_q;
          dst_d      = dst_q + ADDR_ONE;
          pat_d      = inc_q ? pat_q + DATA_ONE : pat_q;
          cnt_d      = cnt_q - CNT_ONE;
        end
      end

      S_RD: begin
        if (copy_q) begin
          // The word read this cycle is forwarded from mem_dout during WR.
          state_d    = S_WR;
          mem_we_d   = 1'b1;
          mem_addr_d = dst_q;
          dst_d      = dst_q + ADDR_ONE;
        end else begin
          if (pend_q) acc_d = acc_q + mem_dout;
          pend_d = 1'b1;
          if (cnt_q == '0) begin
            state_d = S_DRAIN;
          end else begin
            mem_addr_d = src_q;
            src_d      = src_q + ADDR_ONE;
            cnt_d      = cnt_q - CNT_ONE;
          end
        end
      end

      S_WR: begin
        mem_we_d  = 1'b0;
        mem_din_d = mem_dout;
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d    = S_RD;
          mem_addr_d = src_q;
          src_d      = src_q + ADDR_ONE;
          cnt_d      = cnt_q - CNT_ONE;
        end
      end

      S_DRAIN: begin
        result_d = acc_q + mem_dout;
        state_d  = S_DONE;
      end

      S_DONE: begin
        mem_we_d = 1'b0;
        state_d  = S_IDLE;
      end

      default: begin
        mem_we_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      pat_q      <= '0;
      inc_q      <= 1'b0;
      copy_q     <= 1'b0;
      pend_q     <= 1'b0;
      acc_q      <= '0;
      result_q   <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      pat_q      <= pat_d;
      inc_q      <= inc_d;
      copy_q     <= copy_d;
      pend_q     <= pend_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_we_q   <= mem_we_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  // A COPY write carries the word the RAM returns in that same cycle.
  assign mem_din   = (state_q == S_WR) ? mem_dout : mem_din_q;

endmodule

// File: tb/tb_ram_dma_engine.sv
// Self-checking bench for ram_dma_engine: behavioural RAM, array reference model, directed and random commands.
// Honours RAM_DMA_FILL_INC_EN so the same bench covers both builds.
`timescale 1ns/1ps

module tb_ram_dma_engine;
  localparam int A = 10;
  localparam int D = 8;
  localparam int N = 1 << A;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_FILL = 2'b01;
  localparam logic [1:0] OP_SUM  = 2'b10;
  localparam logic [1:0] OP_11   = 2'b11;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [A-1:0] cmd_src;
  logic [A-1:0] cmd_dst;
  logic [A:0]   cmd_len;
  logic [D-1:0] cmd_data;
  logic         busy;
  logic         done;
  logic [D-1:0] result;
  logic [A-1:0] mem_addr;
  logic [D-1:0] mem_din;
  logic         mem_we;
  logic [D-1:0] mem_dout;

  logic [D-1:0] ram [N];
  logic [D-1:0] mdl [N];

  int total = 0;
  int bad   = 0;

  ram_dma_engine #(.A(A), .D(D)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .busy(busy), .done(done), .result(result),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wrec(input int cyc, input int addr, input int dat);
    return (cyc << 18) | (addr << 8) | dat;
  endfunction

  task automatic start_cmd(input logic [1:0] op, input int src, input int dst, input int len, input int data);
    @(negedge clk);
    check("ready_before_cmd", cmd_ready, 1);
    cmd_op    = op;
    cmd_src   = A'(src);
    cmd_dst   = A'(dst);
    cmd_len   = (A+1)'(len);
    cmd_data  = D'(data);
    cmd_valid = 1'b1;
    @(posedge clk);
  endtask

  // Builds the expected outcome from the command rules, then watches the DUT cycle by cycle.
  task automatic monitor(input logic [1:0] op, input int src, input int dst, input int len, input int data,
                         input bit hold, input logic [1:0] n_op, input int n_src, input int n_dst,
                         input int n_len, input int n_data);
    logic [31:0] exp_w[$];
    logic [31:0] obs_w[$];
    int          exp_done;
    int          obs_done;
    int          n_done;
    int          mism;
    int          first_addr;
    int          exp_first;
    bit          res_chk;
    logic [D-1:0] exp_res;
    int          sum;

    exp_res   = '0;
    res_chk   = 1'b0;
    exp_first = -1;
    if (op == OP_NOP || len == 0) begin
      exp_done = 1;
      res_chk  = 1'b1;
    end else if (op == OP_FILL) begin
      exp_done  = len + 1;
      exp_first = dst;
      for (int i = 0; i < len; i++) begin
        mdl[(dst + i) % N] = D'(data);
        exp_w.push_back(wrec(i + 1, (dst + i) % N, data % 256));
      end
    end else if (op == OP_SUM) begin
      exp_done  = len + 2;
      exp_first = src;
      res_chk   = 1'b1;
      sum       = 0;
      for (int i = 0; i < len; i++) sum += int'(mdl[(src + i) % N]);
      exp_res = D'(sum % 256);
    end else begin
`ifdef RAM_DMA_FILL_INC_EN
      exp_done  = len + 1;
      exp_first = dst;
      for (int i = 0; i < len; i++) begin
        mdl[(dst + i) % N] = D'((data + i) % 256);
        exp_w.push_back(wrec(i + 1, (dst + i) % N, (data + i) % 256));
      end
`else
      exp_done  = 2 * len + 1;
      exp_first = src;
      for (int i = 0; i < len; i++) begin
        logic [D-1:0] v;
        v = mdl[(src + i) % N];
        mdl[(dst + i) % N] = v;
        exp_w.push_back(wrec(2 * i + 2, (dst + i) % N, int'(v)));
      end
`endif
    end

    obs_done   = 0;
    n_done     = 0;
    first_addr = -1;
    for (int k = 1; k <= exp_done + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("busy_cycle1", {cmd_ready, busy}, 2'b01);
        first_addr = int'(mem_addr);
        if (!hold) cmd_valid = 1'b0;
      end
      if (mem_we === 1'b1) obs_w.push_back(wrec(k, int'(mem_addr), int'(mem_din)));
      if (done === 1'b1) begin
        n_done++;
        if (obs_done == 0) obs_done = k;
      end
      if (k == exp_done && res_chk) check("result_at_done", result, exp_res);
      if (k == exp_done + 1) begin
        check("ready_after_done", cmd_ready, 1);
        if (res_chk) check("result_held", result, exp_res);
      end
      if (hold) begin
        if (k < exp_done) begin
          cmd_op   = 2'($urandom_range(0, 3));
          cmd_src  = A'($urandom);
          cmd_dst  = A'($urandom);
          cmd_len  = (A+1)'($urandom_range(0, N));
          cmd_data = D'($urandom);
        end else if (k == exp_done) begin
          cmd_op   = n_op;
          cmd_src  = A'(n_src);
          cmd_dst  = A'(n_dst);
          cmd_len  = (A+1)'(n_len);
          cmd_data = D'(n_data);
        end
      end
    end

    check("done_cycle", obs_done, exp_done);
    check("done_pulses", n_done, 1);
    if (exp_first >= 0) check("first_addr", first_addr, exp_first % N);
    check("write_count", obs_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) check("write_rec", obs_w[i], exp_w[i]);
    mism = 0;
    for (int a = 0; a < N; a++) if (ram[a] !== mdl[a]) mism++;
    check("ram_image", mism, 0);
  endtask

  task automatic do_cmd(input logic [1:0] op, input int src, input int dst, input int len, input int data);
    start_cmd(op, src, dst, len, data);
    monitor(op, src, dst, len, data, 1'b0, OP_NOP, 0, 0, 0, 0);
  endtask

  initial begin
    int dn;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_src   = '0;
    cmd_dst   = '0;
    cmd_len   = '0;
    cmd_data  = '0;
    for (int a = 0; a < N; a++) begin
      ram[a] = D'($urandom);
      mdl[a] = ram[a];
    end
    #3;
    check("reset_outputs", {mem_we, mem_addr, mem_din, done, busy, result, cmd_ready},
          {1'b0, 10'h0, 8'h0, 1'b0, 1'b0, 8'h0, 1'b1});
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Wrapping fill, then checksum over it, then a zero-length command.
    do_cmd(OP_FILL, 'h3FE, 'h3FE, 4, 'hA5);
    do_cmd(OP_SUM, 'h3FE, 0, 4, 0);
    check("sum_a5x4", result, 8'h94);
    do_cmd(OP_FILL, 0, 'h123, 0, 'h55);
    check("len0_result", result, 8'h00);
    do_cmd(OP_NOP, 'h10, 'h20, 7, 'h11);

`ifdef RAM_DMA_FILL_INC_EN
    do_cmd(OP_11, 0, 'h100, 3, 'hFE);
    check("fill_inc_wrap", {ram['h100], ram['h101], ram['h102]}, 24'hFEFF00);
    do_cmd(OP_11, 0, 'h3FF, 5, 'h10);
`else
    do_cmd(OP_FILL, 0, 'h10, 1, 'h01);
    do_cmd(OP_FILL, 0, 'h11, 1, 'h02);
    do_cmd(OP_FILL, 0, 'h12, 1, 'h03);
    do_cmd(OP_11, 'h10, 'h20, 3, 0);
    check("copy_dst", {ram['h20], ram['h21], ram['h22]}, 24'h010203);
    do_cmd(OP_11, 'h10, 'h11, 3, 0);
    check("copy_overlap", {ram['h11], ram['h12], ram['h13]}, 24'h010101);
    do_cmd(OP_11, 'h3FD, 'h005, 6, 0);
`endif

    // Full-memory commands: every word touched exactly once.
    do_cmd(OP_FILL, 0, 'h2C7, N, 'h3C);
    do_cmd(OP_SUM, 'h155, 0, N, 0);
    check("sum_full", result, 8'((N * 'h3C) % 256));

    // cmd_valid held with changing fields while busy; next accept only after DONE.
    start_cmd(OP_FILL, 0, 'h50, 5, 'h77);
    monitor(OP_FILL, 0, 'h50, 5, 'h77, 1'b1, OP_SUM, 'h50, 0, 5, 0);
    @(posedge clk);
    monitor(OP_SUM, 'h50, 0, 5, 0, 1'b0, OP_NOP, 0, 0, 0, 0);
    check("sum_after_hold", result, 8'h53);

    // Reset during cycle 2 of an 8-word fill.
    start_cmd(OP_FILL, 0, 'h200, 8, 'h3C);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rst_we_cycle1", mem_we, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_immediate", {mem_we, done, busy, cmd_ready}, 4'b0001);
    dn = 0;
    repeat (2) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1 || mem_we === 1'b1) dn++;
    end
    check("rst_no_done_no_we", dn, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_word0", ram['h200], 8'h3C);
    check("rst_word1", (ram['h201] === mdl['h201]) || (ram['h201] === 8'h3C), 1);
    mdl['h200] = 8'h3C;
    mdl['h201] = ram['h201];
    dn = 0;
    for (int a = 'h202; a < 'h208; a++) if (ram[a] !== mdl[a]) dn++;
    check("rst_untouched", dn, 0);

    // Random commands against the array model.
    for (int t = 0; t < 40; t++) begin
      logic [1:0] op;
      int         len;
      op  = 2'($urandom_range(0, 3));
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(N - 3, N)) : int'($urandom_range(0, 20));
      do_cmd(op, int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)), len, int'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
